// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the request; the slave (the subtractor) returns status and result.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output start, A, B, bin,
      input  busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, A, B, bin,
      output busy, done, diff, bout, ovf
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = A - B - bin, LSB first.
// One full-subtractor cell and one borrow flop process one bit per clock.
// Results are published only when the last bit completes, so partial sums never show.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = $clog2(WIDTH)
) (
   input logic                 clk,
   input logic                 rst_n,
   serial_subtractor_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   logic d_bit;
   logic brw_nxt;
   logic last_bit;

   // Full-subtractor cell on the current LSBs.
   assign d_bit    = sa_q[0] ^ sb_q[0] ^ brw_q;
   assign brw_nxt  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & brw_q);
   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start is only honoured in idle, so nothing queues.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StRun;
         StRun:   if (last_bit) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Status outputs decoded from the registered state.
   always_comb begin
      bus.busy = (state_q == StRun);
      bus.done = (state_q == StDone);
   end

   // Datapath next-state: load on accept, shift while running, publish on the last bit.
   always_comb begin
      sa_d    = sa_q;
      sb_d    = sb_q;
      res_d   = res_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      brw_d   = brw_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               sa_d    = bus.A;
               sb_d    = bus.B;
               brw_d   = bus.bin;
               cnt_d   = '0;
               a_msb_d = bus.A[WIDTH-1];
               b_msb_d = bus.B[WIDTH-1];
            end
         end
         StRun: begin
            sa_d  = {1'b0, sa_q[WIDTH-1:1]};
            sb_d  = {1'b0, sb_q[WIDTH-1:1]};
            res_d = {d_bit, res_q[WIDTH-1:1]};
            brw_d = brw_nxt;
            cnt_d = cnt_q + CW'(1);
            if (last_bit) begin
               diff_d = {d_bit, res_q[WIDTH-1:1]};
               bout_d = brw_nxt;
               // d_bit is the result MSB on the last step.
               ovf_d  = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         brw_q   <= brw_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor. Computes DIFF = A - B - BIN, LSB first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation counterpart of the team's full-adder datapath. It serves area-constrained paths that can accept WIDTH-cycle latency.
- A start/busy/done handshake frames each operation. Results are held until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- CW, $clog2(WIDTH), width of the internal bit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  WIDTH  minuend; sampled on the accepting edge.
- B  input  WIDTH  subtrahend; sampled on the accepting edge.
- bin  input  1  borrow-in; sampled on the accepting edge.
- busy  output  1  high while an operation is in RUN.
- done  output  1  one-cycle pulse; result is valid from this cycle on.
- diff  output  WIDTH  result A - B - bin, mod 2^WIDTH.
- bout  output  1  borrow-out; 1 when A < B + bin, treating the operands as unsigned.
- ovf  output  1  signed overflow flag.

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0. The counter, operand shift registers and borrow flip-flop are all cleared.
- States and transitions:
  - IDLE: on an edge with start=1, latch A into shift register SA, B into SB and bin into the borrow flip-flop. Clear the counter and go to RUN.
  - RUN: each edge computes d = SA[0]^SB[0]^brw and brw_next = (~SA[0]&SB[0]) | (~(SA[0]^SB[0])&brw). d shifts into the MSB of the result register, and SA/SB shift right. The counter increments. On the edge that processes bit WIDTH-1, go to DONE.
  - DONE: lasts one cycle, then the next edge returns to IDLE.
- Outputs are registered and decoded from state: busy=1 iff state==RUN; done=1 iff state==DONE.
- Latency: start accepted at edge k; busy is high from after edge k through edge k+WIDTH; done is high for exactly the cycle after edge k+WIDTH. Accept to done is WIDTH+1 cycles.
- diff, bout and ovf update on the transition into DONE and hold through IDLE until the next DONE. They never show partial results.
- bout is the final borrow flip-flop value.
- ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]), using the latched A and B MSBs. bin does not enter the ovf formula.
- While busy or done, start is ignored and a new request is not queued. A, B and bin may change freely after the accepting edge.
- Back-to-back operation: start held high in the DONE cycle is not accepted. It is accepted on the following edge, when the block is in IDLE. Maximum throughput is one operation per WIDTH+2 cycles.
- Reset asserted mid-operation aborts immediately: all outputs go to their reset values and no done pulse is issued.
- Arithmetic is strictly modulo 2^WIDTH. No saturation.

Test Plan:
- Basic subtract: A=8'd5, B=8'd3, bin=0, start for 1 cycle -> busy high for 8 cycles, then done for 1 cycle; diff=8'h02, bout=0, ovf=0.
- Underflow: A=8'h00, B=8'h01, bin=0 -> diff=8'hFF, bout=1, ovf=0. Then A=8'h80, B=8'h01 -> diff=8'h7F, bout=0, ovf=1.
- Borrow-in chaining: A=8'h10, B=8'h0F, bin=1 -> diff=8'h00, bout=0. Then A=8'h00, B=8'h00, bin=1 -> diff=8'hFF, bout=1.
- Handshake:
  - Pulse start again in the 3rd busy cycle with different operands -> ignored; the result matches the first operands and exactly one done pulse occurs.
  - Hold start high continuously -> operations are accepted every 10 cycles (WIDTH=8).
- Reset mid-run: assert rst_n=0 at busy cycle 4 -> busy, done, diff, bout and ovf go to 0 immediately with no done pulse. After release, a new op A=8'hAA, B=8'h55 gives diff=8'h55, bout=0, ovf=1.
- Random: 1000 random A, B, bin at WIDTH=8 and WIDTH=16 -> diff, bout and ovf match a reference model; diff holds stable between done pulses.
